// File: rtl/icache_tag_array.sv
// icache_tag_array: per-way tag RAMs with valid bits, 1-cycle lookup, round-robin victim
// pointer and a one-set-per-cycle invalidate sweep that also runs out of reset.
module icache_tag_array #(
   parameter int WAYS      = 2,
   parameter int SETS_LOG2 = 8,
   parameter int TAG_WIDTH = 21
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 lookup_en,
   input  logic [SETS_LOG2-1:0] lookup_index,
   input  logic [TAG_WIDTH-1:0] lookup_tag,
   output logic                 rsp_valid,
   output logic                 rsp_hit,
   output logic [WAYS-1:0]      rsp_way,
   output logic [WAYS-1:0]      victim_way,
   input  logic                 fill_en,
   input  logic [SETS_LOG2-1:0] fill_index,
   input  logic [TAG_WIDTH-1:0] fill_tag,
   input  logic [WAYS-1:0]      fill_way,
   input  logic                 inv_req,
   output logic                 busy
);
   localparam int SETS = 1 << SETS_LOG2;
   localparam int VW   = (WAYS > 1) ? $clog2(WAYS) : 1;

   typedef enum logic {IDLE, SWEEP} state_t;

   state_t               r_state, w_next;
   logic [SETS_LOG2-1:0] r_cnt;
   logic [VW-1:0]        r_vptr;
   logic [WAYS-1:0]      r_valid [SETS];
   logic [WAYS-1:0]      r_vrd;
   logic [TAG_WIDTH-1:0] r_tag;
   logic                 r_rsp_valid, r_kill;
   logic                 w_fill;
   logic [WAYS-1:0]      w_match;

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= SWEEP;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = (r_state == IDLE) ? (inv_req ? SWEEP : IDLE) : (&r_cnt ? IDLE : SWEEP);
   end

   always_comb begin
      busy       = (r_state == SWEEP);
      w_fill     = fill_en && (r_state == IDLE) && !inv_req;
      rsp_valid  = r_rsp_valid;
      rsp_way    = (r_rsp_valid && !r_kill) ? w_match : '0;
      rsp_hit    = |rsp_way;
      victim_way = WAYS'(1) << r_vptr;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cnt       <= '0;
         r_vptr      <= '0;
         r_rsp_valid <= 1'b0;
      end else begin
         r_rsp_valid <= lookup_en;
         if (busy) r_cnt <= r_cnt + 1'b1;
         if (w_fill && |fill_way) r_vptr <= (r_vptr == VW'(WAYS - 1)) ? '0 : r_vptr + 1'b1;
      end
   end

   // Read-old: the valid/tag snapshot is taken before any same-edge fill lands.
   always_ff @(posedge clk) begin
      r_kill <= busy || inv_req;
      r_tag  <= lookup_tag;
      r_vrd  <= r_valid[lookup_index];
   end

   always_ff @(posedge clk) begin
      if (busy) r_valid[r_cnt] <= '0;
      else if (w_fill)
         for (int w = 0; w < WAYS; w++)
            if (fill_way[w]) r_valid[fill_index][w] <= 1'b1;
   end

   for (genvar g = 0; g < WAYS; g++) begin : g_way
      logic [TAG_WIDTH-1:0] r_mem [SETS];
      logic [TAG_WIDTH-1:0] r_trd;
      always_ff @(posedge clk) begin
         if (w_fill && fill_way[g]) r_mem[fill_index] <= fill_tag;
         r_trd <= r_mem[lookup_index];
      end
      assign w_match[g] = r_vrd[g] && (r_trd == r_tag);
   end
endmodule

// File: doc/icache_tag_array.md
ICACHE_TAG_ARRAY -- requirements
Module: icache_tag_array

Interface
REQ-001 SHALL have parameter WAYS, default 2, number of ways; legal values 1, 2, 4.
REQ-002 SHALL have parameter SETS_LOG2, default 8, set-index width (2^SETS_LOG2 sets).
REQ-003 SHALL have parameter TAG_WIDTH, default 21, stored tag width.
REQ-004 clk  in  1  single clock; all logic on the rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 lookup_en  in  1  lookup request qualifier.
REQ-007 lookup_index  in  SETS_LOG2  set to look up.
REQ-008 lookup_tag  in  TAG_WIDTH  tag to compare.
REQ-009 rsp_valid  out  1  lookup result valid.
REQ-010 rsp_hit  out  1  at least one valid way matched.
REQ-011 rsp_way  out  WAYS  one-hot (or multi-hot) matching ways.
REQ-012 victim_way  out  WAYS  one-hot way to replace on next fill.
REQ-013 fill_en  in  1  fill request qualifier.
REQ-014 fill_index  in  SETS_LOG2  set to write.
REQ-015 fill_tag  in  TAG_WIDTH  tag to write.
REQ-016 fill_way  in  WAYS  ways to write; each set bit written.
REQ-017 inv_req  in  1  single-cycle pulse, invalidate whole array.
REQ-018 busy  out  1  invalidate sweep in progress.

Function
REQ-019 Storage SHALL be one tag memory per way (2^SETS_LOG2 x TAG_WIDTH, inferable block RAM, registered read) plus one valid bit per set per way.
REQ-020 Lookup SHALL have latency 1: lookup_en at edge N -> rsp_valid=1 for exactly one cycle after edge N+1 with rsp_hit/rsp_way for that request.
REQ-021 rsp_way[w] SHALL be 1 iff valid[index][w]=1 and stored tag == registered lookup_tag; rsp_hit = OR of rsp_way.
REQ-022 rsp_hit and rsp_way SHALL be 0 whenever rsp_valid=0.
REQ-023 Fill accepted (fill_en=1, busy=0) SHALL write fill_tag and set valid for every way with fill_way bit set, at the same index; fill_way=0 SHALL write nothing.
REQ-024 Lookup and accepted fill to the same index in the same cycle SHALL return the pre-fill contents (read-old); the fill SHALL be visible to lookups issued one or more cycles later.
REQ-025 victim_way SHALL be a global round-robin pointer, one-hot, starting at way 0, advancing by one way (wrapping WAYS-1 -> 0) on each accepted fill with fill_way != 0; WAYS=1 -> victim_way constant 1.
REQ-026 FSM states IDLE, SWEEP. IDLE -> SWEEP on inv_req=1; SWEEP clears valid bits of set k for all ways in cycle k, k=0..2^SETS_LOG2-1; SWEEP -> IDLE after set 2^SETS_LOG2-1 is cleared.
REQ-027 busy SHALL be 1 in every SWEEP cycle, exactly 2^SETS_LOG2 cycles per sweep, and 0 in IDLE.
REQ-028 While busy=1: fill_en SHALL be ignored; lookups SHALL still produce rsp_valid=1 with rsp_hit=0, rsp_way=0.
REQ-029 inv_req during SWEEP SHALL be ignored (sweep not restarted, not extended).
REQ-030 inv_req and fill_en in the same IDLE cycle: invalidate wins, fill dropped, victim pointer unchanged.
REQ-031 Lookup issued in the cycle inv_req is accepted SHALL return miss.

Reset
REQ-032 rst_n=0 sampled at an edge SHALL set rsp_valid=0, rsp_hit=0, rsp_way=0, victim_way=way 0 one-hot, sweep counter=0, and place the FSM in SWEEP with busy=1.
REQ-033 After rst_n returns to 1 the sweep SHALL run the full 2^SETS_LOG2 cycles; tag memory contents need not be reset.
REQ-034 Reset asserted mid-sweep or mid-lookup SHALL abandon the operation and restart per REQ-032; no rsp_valid pulse from a pre-reset lookup.

Verification
REQ-035 Reset release, defaults -> busy=1 for exactly 256 cycles, then 0; lookup index 0x05 tag 0x12345 after busy=0 -> rsp_valid=1, rsp_hit=0.
REQ-036 Fill index 0x3A tag 0x1ABCD way 2'b10, then lookup 0x3A/0x1ABCD -> rsp_hit=1, rsp_way=2'b10; lookup 0x3A/0x1ABCE -> rsp_hit=0.
REQ-037 Lookup and fill index 0x10 tag 0x00077 same cycle -> miss; same lookup next cycle -> hit on filled way.
REQ-038 Three accepted fills from reset (WAYS=2) -> victim_way 2'b01 -> 2'b10 -> 2'b01 -> 2'b10; fill with fill_way=0 -> victim unchanged.
REQ-039 Fill sets 0x00 and 0xFF, pulse inv_req with simultaneous fill to 0x80 -> busy 256 cycles, fill dropped, second inv_req at sweep cycle 100 ignored, all three sets miss afterwards.
REQ-040 Assert rst_n=0 at sweep cycle 50 for one cycle -> busy stays 1 for a full 256 cycles after release; WAYS=4, SETS_LOG2=6 repeat of REQ-035/036 -> busy 64 cycles, hit on the filled way only.
